// File: rtl/mips_memory.sv
// Word memory on the multicycle MIPS processor bus: one-cycle registered reads, plus a
// valid/ready program-loader port that owns the array while its FSM is out of IDLE.
module mips_memory #(
  parameter int DEPTH     = 64,
  parameter int INIT_ZERO = 1,
  localparam int IW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   addr,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [31:0]   writedata,
  output logic [31:0]   memdata,
  input  logic          load_mode,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic [IW:0]   load_count,
  output logic          misalign_err,
  output logic          range_err
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || (INIT_ZERO != 0 && INIT_ZERO != 1)) begin : g_param_check
    $error("mips_memory: DEPTH must be a power of two >= 4 and INIT_ZERO must be 0 or 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   count_q, count_d;
  logic [31:0]   memdata_q, memdata_d;
  logic          load_ready_q, load_ready_d;
  logic          load_done_q, load_done_d;
  logic          misalign_q, misalign_d;
  logic          range_q, range_d;

  // No reset on the array: contents must survive a processor reset.
  logic [31:0]   mem_q [DEPTH];
  logic          mem_we;
  logic [IW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  logic [IW-1:0] idx;
  logic          in_range;
  logic          proc_access;
  logic          accept;

  assign idx         = addr[IW+1:2];
  assign in_range    = (addr[31:IW+2] == '0);
  assign proc_access = (state_q == ST_IDLE) && (memread || memwrite);
  assign accept      = (state_q == ST_LOAD) && load_valid && load_ready_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    memdata_d  = memdata_q;
    misalign_d = misalign_q;
    range_d    = range_q;
    mem_we     = 1'b0;
    mem_widx   = '0;
    mem_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        if (load_mode) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          mem_we    = 1'b1;
          mem_widx  = ptr_q;
          mem_wdata = load_data;
          ptr_d     = ptr_q + 1'b1;
          count_d   = count_q + 1'b1;
          if (ptr_q == IW'(DEPTH - 1)) begin
            state_d = ST_DONE;
          end
        end
        // Dropping load_mode ends the session, but a word offered alongside it still lands.
        if (!load_mode) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!load_mode) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (proc_access) begin
      if (addr[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
      if (!in_range) begin
        range_d = 1'b1;
      end
      // Read samples the array before this edge's write, giving read-before-write.
      if (memread) begin
        memdata_d = in_range ? mem_q[idx] : 32'h0;
      end
      if (memwrite && in_range) begin
        mem_we    = 1'b1;
        mem_widx  = idx;
        mem_wdata = writedata;
      end
    end

    load_ready_d = (state_d == ST_LOAD);
    load_done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      count_q      <= '0;
      memdata_q    <= '0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      misalign_q   <= 1'b0;
      range_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      memdata_q    <= memdata_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      misalign_q   <= misalign_d;
      range_q      <= range_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  assign memdata      = memdata_q;
  assign load_ready   = load_ready_q;
  assign load_done    = load_done_q;
  assign load_count   = count_q;
  assign misalign_err = misalign_q;
  assign range_err    = range_q;

endmodule

// File: tb/tb_mips_memory.sv
// Directed bench for mips_memory: expected read data queued at issue, compared one cycle later.
module tb_mips_memory;

  localparam int DEPTH = 64;
  localparam int IW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   addr;
  logic          memread;
  logic          memwrite;
  logic [31:0]   writedata;
  logic [31:0]   memdata;
  logic          load_mode;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_ready;
  logic          load_done;
  logic [IW:0]   load_count;
  logic          misalign_err;
  logic          range_err;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   prog[4];

  mips_memory #(.DEPTH(DEPTH), .INIT_ZERO(1)) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .memread(memread),
    .memwrite(memwrite),
    .writedata(writedata),
    .memdata(memdata),
    .load_mode(load_mode),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .load_done(load_done),
    .load_count(load_count),
    .misalign_err(misalign_err),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s observed=%h expected=<no queued entry>", tag, memdata);
    end else begin
      check(tag, memdata, exp_q.pop_front());
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    writedata = d;
    memwrite  = 1'b1;
    memread   = 1'b0;
    tick();
    memwrite  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    addr     = a;
    memread  = 1'b1;
    memwrite = 1'b0;
    exp_q.push_back(e);
    tick();
    memread  = 1'b0;
    pop_check(tag);
  endtask

  initial begin
    prog[0] = 32'h20020005;
    prog[1] = 32'h2003000C;
    prog[2] = 32'hAC020040;
    prog[3] = 32'h8C040040;

    reset = 1'b0; addr = '0; memread = 1'b0; memwrite = 1'b0; writedata = '0;
    load_mode = 1'b0; load_valid = 1'b0; load_data = '0;
    tick();
    tick();
    check("rst_memdata", memdata, 32'h0);
    check("rst_load_ready", {31'b0, load_ready}, 32'h0);
    check("rst_load_done", {31'b0, load_done}, 32'h0);
    check("rst_load_count", {25'b0, load_count}, 32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'h0);
    check("rst_range", {31'b0, range_err}, 32'h0);
    reset = 1'b1;

    // Program load of four words; load_mode drops with the last word.
    load_mode = 1'b1;
    tick();
    check("ld4_ready_on_entry", {31'b0, load_ready}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_mode  = (i != 3);
      tick();
    end
    load_valid = 1'b0;
    check("ld4_done", {31'b0, load_done}, 32'h1);
    check("ld4_ready_off", {31'b0, load_ready}, 32'h0);
    check("ld4_count", {25'b0, load_count}, 32'd4);
    tick();
    check("ld4_back_idle_done", {31'b0, load_done}, 32'h0);
    check("ld4_count_held", {25'b0, load_count}, 32'd4);
    rd("ld4_read_0x8", 32'h8, 32'hAC020040);
    rd("ld4_read_0x0", 32'h0, 32'h20020005);
    rd("ld4_read_0xC", 32'hC, 32'h8C040040);

    // Write then read back, then hold with memread low.
    wr(32'h40, 32'hDEADBEEF);
    rd("wr_read_0x40", 32'h40, 32'hDEADBEEF);
    addr = 32'h0;
    tick();
    check("hold_no_read", memdata, 32'hDEADBEEF);

    // Read-before-write on the same index.
    wr(32'h10, 32'h11111111);
    addr = 32'h10; writedata = 32'h22222222; memread = 1'b1; memwrite = 1'b1;
    exp_q.push_back(32'h11111111);
    tick();
    memread = 1'b0; memwrite = 1'b0;
    pop_check("rbw_old_data");
    rd("rbw_new_data", 32'h10, 32'h22222222);

    // Range and alignment errors.
    rd("range_read_zero", 32'h100, 32'h0);
    check("range_flag_set", {31'b0, range_err}, 32'h1);
    check("misalign_still_clear", {31'b0, misalign_err}, 32'h0);
    wr(32'h42, 32'h42424242);
    check("misalign_flag_set", {31'b0, misalign_err}, 32'h1);
    rd("misalign_stored_idx16", 32'h40, 32'h42424242);
    wr(32'h104, 32'h77777777);
    rd("range_write_suppressed", 32'h4, 32'h2003000C);
    tick();
    tick();
    check("range_sticky", {31'b0, range_err}, 32'h1);
    check("misalign_sticky", {31'b0, misalign_err}, 32'h1);

    // Full-depth load with continuous valid.
    load_mode = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hA5000000 | i;
      tick();
      if (i == DEPTH - 2) begin
        check("full_ready_before_last", {31'b0, load_ready}, 32'h1);
      end
    end
    check("full_ready_dropped", {31'b0, load_ready}, 32'h0);
    check("full_done", {31'b0, load_done}, 32'h1);
    check("full_count", {25'b0, load_count}, 32'd64);
    load_data = 32'hFFFFFFFF;
    tick();
    check("full_count_no_wrap", {25'b0, load_count}, 32'd64);
    load_valid = 1'b0;
    load_mode  = 1'b0;
    tick();
    check("full_idle_done_clear", {31'b0, load_done}, 32'h0);
    rd("full_word0_kept", 32'h0, 32'hA5000000);
    rd("full_word63", 32'hFC, 32'hA500003F);
    check("flags_survive_load", {30'b0, range_err, misalign_err}, 32'h3);

    // Reset in the middle of a load; processor traffic during LOAD is ignored.
    load_mode = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hB0000000 + i;
      addr = 32'h20; writedata = 32'hBADBAD00; memwrite = 1'b1; memread = 1'b1;
      tick();
    end
    memwrite = 1'b0; memread = 1'b0; load_valid = 1'b0;
    check("load_memdata_held", memdata, 32'hA500003F);
    check("midload_count", {25'b0, load_count}, 32'd3);
    #1;
    reset = 1'b0;
    load_mode = 1'b0;
    #1;
    check("midrst_memdata", memdata, 32'h0);
    check("midrst_ready", {31'b0, load_ready}, 32'h0);
    check("midrst_count", {25'b0, load_count}, 32'h0);
    check("midrst_flags", {29'b0, load_done, range_err, misalign_err}, 32'h0);
    #2;
    reset = 1'b1;
    tick();
    rd("midrst_word0", 32'h0, 32'hB0000000);
    rd("midrst_word1", 32'h4, 32'hB0000001);
    rd("midrst_word2", 32'h8, 32'hB0000002);
    rd("load_blocks_proc_write", 32'h20, 32'hA5000008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
